// File: rtl/conv_pkg.sv
// Shared types and configuration for the convolution output path.
package conv_pkg;

   typedef struct packed {
      int unsigned data_width;
      int unsigned feature_map_width;
      int unsigned feature_map_height;
      int unsigned output_nb_channels;
      int unsigned fifo_depth;
      int unsigned energy_width;
   } config_t;

   localparam config_t CFG_DEFAULT = '{
      data_width:         16,
      feature_map_width:  128,
      feature_map_height: 128,
      output_nb_channels: 64,
      fifo_depth:         2,
      energy_width:       32
   };

   localparam int unsigned STRIDE_MAX = 3;

   typedef enum logic [1:0] {
      STRIDE_1 = 2'd0,
      STRIDE_2 = 2'd1,
      STRIDE_4 = 2'd2,
      STRIDE_8 = 2'd3
   } stride_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } tagger_state_e;

   // Index width that never collapses to zero bits for degenerate sizes.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   typedef struct packed {
      logic signed [CFG_DEFAULT.data_width-1:0]                       data;
      logic [clog2_min1(CFG_DEFAULT.feature_map_width)-1:0]           x;
      logic [clog2_min1(CFG_DEFAULT.feature_map_height)-1:0]          y;
      logic [clog2_min1(CFG_DEFAULT.output_nb_channels)-1:0]          ch;
      logic                                                           last;
   } tag_t;

endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO of tagged beats; the head entry drives the consumer directly.
module tag_fifo
   import conv_pkg::*;
#(
   parameter type         T     = tag_t,
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic arst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = clog2_min1(DEPTH);

   T               mem_q [DEPTH];
   T               mem_d [DEPTH];
   logic [AW:0]    wr_q, wr_d;
   logic [AW:0]    rd_q, rd_d;
   logic           do_push, do_pop;

   always_comb begin
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      // A pop in the same cycle frees the slot, so push is legal even when full.
      do_pop  = pop && !empty;
      do_push = push && (!full || pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (do_push) begin
         mem_d[wr_q[AW-1:0]] = push_data;
         wr_d                = wr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + (AW+1)'(1);
      end
      head = mem_q[rd_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/conv_output_tagger.sv
// Tags conv results with (x, y, ch), buffers them with ready/valid flow control
// and accumulates a saturating count of transferred output bits.
module conv_output_tagger
   import conv_pkg::*;
#(
   parameter config_t     cfg = CFG_DEFAULT,
   localparam int unsigned DW  = cfg.data_width,
   localparam int unsigned FMW = cfg.feature_map_width,
   localparam int unsigned FMH = cfg.feature_map_height,
   localparam int unsigned NCH = cfg.output_nb_channels,
   localparam int unsigned EW  = cfg.energy_width,
   localparam int unsigned XW  = clog2_min1(FMW),
   localparam int unsigned YW  = clog2_min1(FMH),
   localparam int unsigned CW  = clog2_min1(NCH)
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 start,
   input  logic [1:0]           conv_stride_mode,
   input  logic [DW-1:0]        in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [DW-1:0] output_data,
   output logic                 output_valid,
   input  logic                 output_ready,
   output logic [XW-1:0]        output_x,
   output logic [YW-1:0]        output_y,
   output logic [CW-1:0]        output_ch,
   output logic                 output_last,
   output logic                 running,
   output logic                 done,
   output logic [EW-1:0]        energy,
   input  logic                 energy_clear
);

   typedef struct packed {
      logic signed [DW-1:0] data;
      logic [XW-1:0]        x;
      logic [YW-1:0]        y;
      logic [CW-1:0]        ch;
      logic                 last;
   } beat_t;

   tagger_state_e  state_q, state_d;
   stride_mode_e   stride_q, stride_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [CW-1:0]  ch_q, ch_d;
   logic           running_q, running_d;
   logic [EW-1:0]  energy_q, energy_d;

   int unsigned    ow, oh;
   logic           x_last, y_last, ch_last, last_beat, accept;
   logic           fifo_full, fifo_empty;
   logic [EW:0]    inc, energy_sum;
   beat_t          push_beat, head_beat;

   tag_fifo #(
      .T     (beat_t),
      .DEPTH (cfg.fifo_depth)
   ) u_fifo (
      .clk       (clk),
      .arst      (arst),
      .push      (accept),
      .push_data (push_beat),
      .pop       (output_ready),
      .head      (head_beat),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      ow = FMW >> stride_q;
      oh = FMH >> stride_q;
      if (ow == 0) ow = 1;
      if (oh == 0) oh = 1;
      x_last    = (x_q == XW'(ow - 1));
      y_last    = (y_q == YW'(oh - 1));
      ch_last   = (ch_q == CW'(NCH - 1));
      last_beat = x_last && y_last && ch_last;

      // in_ready depends only on registered state, never on output_ready.
      in_ready  = (state_q == RUN) && !fifo_full;
      accept    = in_valid && in_ready;
      push_beat = '{data: in_data, x: x_q, y: y_q, ch: ch_q, last: last_beat};

      state_d   = state_q;
      stride_d  = stride_q;
      x_d       = x_q;
      y_d       = y_q;
      ch_d      = ch_q;
      running_d = running_q;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               stride_d  = stride_mode_e'(conv_stride_mode);
               x_d       = '0;
               y_d       = '0;
               ch_d      = '0;
               running_d = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               if (!ch_last) begin
                  ch_d = ch_q + CW'(1);
               end else begin
                  ch_d = '0;
                  if (!x_last) begin
                     x_d = x_q + XW'(1);
                  end else begin
                     x_d = '0;
                     y_d = y_last ? '0 : y_q + YW'(1);
                  end
               end
               if (last_beat) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               done      = 1'b1;
               running_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      output_valid = !fifo_empty;
      output_data  = head_beat.data;
      output_x     = head_beat.x;
      output_y     = head_beat.y;
      output_ch    = head_beat.ch;
      output_last  = head_beat.last;
      running      = running_q;
      energy       = energy_q;

      inc        = (output_valid && output_ready) ? (EW+1)'(DW) : '0;
      energy_sum = {1'b0, energy_q} + inc;
      if (energy_clear) begin
         energy_d = inc[EW-1:0];
      end else begin
         energy_d = energy_sum[EW] ? '1 : energy_sum[EW-1:0];
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         stride_q  <= STRIDE_1;
         x_q       <= '0;
         y_q       <= '0;
         ch_q      <= '0;
         running_q <= 1'b0;
         energy_q  <= '0;
      end else begin
         state_q   <= state_d;
         stride_q  <= stride_d;
         x_q       <= x_d;
         y_q       <= y_d;
         ch_q      <= ch_d;
         running_q <= running_d;
         energy_q  <= energy_d;
      end
   end

endmodule

// File: tb/tb_conv_output_tagger.sv
// Directed bench: 4x4 map, 2 channels, depth-2 FIFO; a second instance with an 8-bit energy counter.
module tb_conv_output_tagger;
   import conv_pkg::*;

   localparam config_t CFG_A = '{data_width: 16, feature_map_width: 4, feature_map_height: 4,
                                 output_nb_channels: 2, fifo_depth: 2, energy_width: 32};
   localparam config_t CFG_B = '{data_width: 16, feature_map_width: 4, feature_map_height: 4,
                                 output_nb_channels: 2, fifo_depth: 2, energy_width: 8};

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  x;
      logic [1:0]  y;
      logic        ch;
      logic        last;
   } obeat_t;

   typedef struct {
      logic [1:0] mode;
      int         rmode;
      int         beats;
      int         max_occ;
   } vec_t;

   logic clk = 1'b0;
   logic arst, start, in_valid, out_ready, energy_clear;
   logic [1:0] mode;
   logic [15:0] in_data;
   logic in_ready, ov, o_last, running, done;
   logic signed [15:0] o_data;
   logic [1:0] o_x, o_y;
   logic o_ch;
   logic [31:0] energy_a;
   logic in_ready_b, ov_b, o_last_b, running_b, done_b;
   logic signed [15:0] o_data_b;
   logic [1:0] o_x_b, o_y_b;
   logic o_ch_b;
   logic [7:0] energy_b;

   int tests = 0;
   int fails = 0;
   obeat_t cap[$];
   int done_total = 0;
   int stall_checks = 0;
   int stall_bad = 0;
   logic prev_stall = 1'b0;
   obeat_t prev_beat = '0;
   obeat_t cur_beat;
   vec_t vec[4];

   always #5 clk = ~clk;

   conv_output_tagger #(.cfg(CFG_A)) dut_a (
      .clk(clk), .arst(arst), .start(start), .conv_stride_mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .output_data(o_data), .output_valid(ov), .output_ready(out_ready),
      .output_x(o_x), .output_y(o_y), .output_ch(o_ch), .output_last(o_last),
      .running(running), .done(done), .energy(energy_a), .energy_clear(energy_clear)
   );

   conv_output_tagger #(.cfg(CFG_B)) dut_b (
      .clk(clk), .arst(arst), .start(start), .conv_stride_mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
      .output_data(o_data_b), .output_valid(ov_b), .output_ready(out_ready),
      .output_x(o_x_b), .output_y(o_y_b), .output_ch(o_ch_b), .output_last(o_last_b),
      .running(running_b), .done(done_b), .energy(energy_b), .energy_clear(energy_clear)
   );

   assign cur_beat = '{data: o_data, x: o_x, y: o_y, ch: o_ch, last: o_last};

   // Sampled on the falling edge: what is seen here is what the next rising edge transfers.
   always @(negedge clk) begin
      if (arst) begin
         prev_stall <= 1'b0;
      end else begin
         if (ov && out_ready) cap.push_back(cur_beat);
         if (done) done_total <= done_total + 1;
         if (prev_stall) begin
            stall_checks <= stall_checks + 1;
            if (cur_beat != prev_beat) stall_bad <= stall_bad + 1;
         end
         prev_stall <= ov && !out_ready;
         prev_beat  <= cur_beat;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_energy();
      @(posedge clk); #1 energy_clear = 1'b1;
      @(posedge clk); #1 energy_clear = 1'b0;
   endtask

   // Runs one layer; rmode 0 = sink always ready, 1 = ready one cycle in three.
   task automatic run_layer(input logic [1:0] m, input int rmode, input int pulse_at,
                            output int n, output int base, output int pulses, output int max_occ);
      int cyc, d0, occ;
      bit acc, pulsed;
      cyc = 0; n = 0; max_occ = 0; pulsed = 0;
      base = cap.size();
      d0 = done_total;
      @(posedge clk); #1 mode = m; start = 1'b1; out_ready = (rmode == 0);
      @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 16'd0;
      while (done_total == d0 && cyc < 3000) begin
         @(negedge clk); acc = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         mode = m;
         if (acc) n++;
         in_data = 16'(n);
         out_ready = (rmode == 0) || (cyc % 3 == 0);
         occ = n - (cap.size() - base);
         if (occ > max_occ) max_occ = occ;
         if (pulse_at > 0 && n == pulse_at && !pulsed) begin
            start = 1'b1;
            mode = ~m;
            pulsed = 1;
         end
      end
      check("layer_timeout", longint'(cyc >= 3000), 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (in_valid && in_ready) n++;
         check("in_ready_after_layer", in_ready, 0);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      pulses = done_total - d0;
   endtask

   task automatic check_tags(input logic [1:0] m, input int base, input int beats);
      int i, ow, oh, got;
      obeat_t exp;
      ow = 4 >> m;
      oh = 4 >> m;
      got = cap.size() - base;
      check($sformatf("beat_count_m%0d", m), got, beats);
      i = 0;
      for (int y = 0; y < oh; y++)
         for (int x = 0; x < ow; x++)
            for (int c = 0; c < 2; c++) begin
               exp = '{data: 16'(i), x: 2'(x), y: 2'(y), ch: 1'(c), last: (i == beats - 1)};
               if (i < got) check($sformatf("tag_m%0d_beat%0d", m, i), cap[base + i], exp);
               i++;
            end
   endtask

   initial begin
      int n, base, pulses, occ, cyc, d0;
      bit acc;
      arst = 1'b1; start = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; energy_clear = 1'b0;
      vec[0] = '{mode: 2'd0, rmode: 0, beats: 32, max_occ: 1};
      vec[1] = '{mode: 2'd1, rmode: 0, beats: 8,  max_occ: 1};
      vec[2] = '{mode: 2'd0, rmode: 1, beats: 32, max_occ: 2};
      vec[3] = '{mode: 2'd2, rmode: 0, beats: 2,  max_occ: 1};

      repeat (3) @(posedge clk);
      #1 arst = 1'b0;
      @(negedge clk);
      check("rst_output_valid", ov, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_energy", energy_a, 0);
      check("rst_energy_b", energy_b, 0);
      check("rst_output_data", o_data, 0);
      check("rst_output_x", o_x, 0);
      check("rst_output_y", o_y, 0);
      check("rst_output_ch", o_ch, 0);
      check("rst_output_last", o_last, 0);

      @(posedge clk); #1 in_valid = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      @(posedge clk); #1 in_valid = 1'b0;

      // Reset in the middle of a layer.
      d0 = done_total;
      @(posedge clk); #1 mode = 2'd0; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 16'd0;
      n = 0; cyc = 0;
      while (n < 5 && cyc < 50) begin
         @(negedge clk); acc = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) n++;
         in_data = 16'(n);
      end
      check("pre_reset_running", running, 1);
      check("pre_reset_energy_nonzero", longint'(energy_a != 0), 1);
      #1 arst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("midrst_output_valid", ov, 0);
      check("midrst_running", running, 0);
      check("midrst_energy", energy_a, 0);
      check("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1 arst = 1'b0;
      check("midrst_no_done", done_total - d0, 0);

      for (int v = 0; v < 4; v++) begin
         clear_energy();
         run_layer(vec[v].mode, vec[v].rmode, 0, n, base, pulses, occ);
         check($sformatf("accepted_v%0d", v), n, vec[v].beats);
         check($sformatf("done_pulses_v%0d", v), pulses, 1);
         check($sformatf("max_occupancy_v%0d", v), occ, vec[v].max_occ);
         check($sformatf("energy_v%0d", v), energy_a, vec[v].beats * 16);
         check($sformatf("energy_b_v%0d", v), energy_b, (vec[v].beats * 16 > 255) ? 255 : vec[v].beats * 16);
         check($sformatf("running_after_v%0d", v), running, 0);
         check_tags(vec[v].mode, base, vec[v].beats);
      end

      // start and stride change while running must be ignored.
      run_layer(2'd1, 0, 3, n, base, pulses, occ);
      check("pulse_accepted", n, 8);
      check("pulse_done", pulses, 1);
      check_tags(2'd1, base, 8);

      // 16 beats: narrow counter saturates.
      clear_energy();
      run_layer(2'd1, 0, 0, n, base, pulses, occ);
      run_layer(2'd1, 0, 0, n, base, pulses, occ);
      check("sat16_energy", energy_a, 256);
      check("sat16_energy_b", energy_b, 255);

      // energy_clear in the same cycle as a transferred beat.
      d0 = done_total;
      base = cap.size();
      @(posedge clk); #1 mode = 2'd2; start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 16'h00AB;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("held_valid", ov, 1);
      check("held_data", o_data, 16'h00AB);
      check("held_ch", o_ch, 0);
      @(posedge clk); #1 out_ready = 1'b1; energy_clear = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0; energy_clear = 1'b0;
      @(negedge clk);
      check("clear_beat_energy", energy_a, 16);
      check("clear_beat_energy_b", energy_b, 16);
      check("clear_beat_valid", ov, 0);
      @(posedge clk); #1 in_valid = 1'b1; in_data = 16'h00CD; out_ready = 1'b1;
      cyc = 0;
      while (done_total == d0 && cyc < 50) begin
         @(posedge clk); #1 cyc++;
         in_valid = 1'b0;
      end
      check("clear_layer_timeout", longint'(cyc >= 50), 0);
      check("clear_layer_energy", energy_a, 32);
      check("clear_layer_beats", cap.size() - base, 2);
      if (cap.size() - base == 2)
         check("clear_layer_last_tag", cap[base + 1], {16'h00CD, 2'd0, 2'd0, 1'b1, 1'b1});

      check("stall_seen", longint'(stall_checks > 0), 1);
      check("stall_stable", stall_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
